// File: rtl/stream_demux4_if.sv
// ---------------------------------------------------------------------------
// stream_demux4_if
//   Bundles the stream signals of stream_demux4. There is one valid/ready
//   input stream and four output channels.
//
//   Signals:
//     in_data   [WIDTH]  input beat payload
//     in_sel    [2]      destination channel (00->ch1 .. 11->ch4), first beat only
//     in_last   [1]      final beat of a burst
//     in_valid  [1]      input beat present
//     in_ready  [1]      demux accepts the beat this cycle
//     outN_data [WIDTH]  held payload of channel N
//     out_valid [4]      bit k-1: channel k holds a beat
//     out_last  [4]      bit k-1: held beat of channel k ends a burst
//     out_ready [4]      bit k-1: consumer of channel k accepts
//
//   Modports:
//     master : producer and consumers (drives in_*, out_ready)
//     slave  : the demux itself
// ---------------------------------------------------------------------------
interface stream_demux4_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out1_data;
    logic [WIDTH-1:0] out2_data;
    logic [WIDTH-1:0] out3_data;
    logic [WIDTH-1:0] out4_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_last;
    logic [3:0]       out_ready;

    modport master (
        output in_data,
        output in_sel,
        output in_last,
        output in_valid,
        input  in_ready,
        input  out1_data,
        input  out2_data,
        input  out3_data,
        input  out4_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_last,
        input  in_valid,
        output in_ready,
        output out1_data,
        output out2_data,
        output out3_data,
        output out4_data,
        output out_valid,
        output out_last,
        input  out_ready
    );
endinterface

// File: rtl/stream_demux4.sv
// ---------------------------------------------------------------------------
// stream_demux4
//   Registered 1-to-4 stream demultiplexer. A single valid/ready input stream
//   is routed to one of four output channels. The 2-bit select is taken from
//   the first beat of a burst and held until the beat carrying in_last, so
//   bursts never interleave across channels. Each channel has a one-entry
//   holding slot that drains independently of the others.
//
//   Ports:
//     clk  : clock, all state changes on the rising edge
//     rst  : synchronous active-high reset; clears the FSM and all slots
//     bus  : stream_demux4_if.slave (input stream + four output channels)
//
//   Parameters:
//     WIDTH : payload width of the input and of every output channel
// ---------------------------------------------------------------------------
module stream_demux4 #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    stream_demux4_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       sel_latched;
    logic [1:0]       sel_next;

    logic [1:0]       target;
    logic             accept;
    logic [3:0]       load;
    logic [3:0]       drain;

    logic [WIDTH-1:0] slot_data [4];
    logic [3:0]       slot_valid;
    logic [3:0]       slot_last;

    // Inside a burst the latched select owns routing, so a producer changing
    // in_sel mid-burst cannot split the burst across channels.
    always_comb begin
        target = bus.in_sel;
        if (state == BURST) begin
            target = sel_latched;
        end
    end

    // A slot can take a new beat when it is empty, or when it drains on the
    // same edge. Including out_ready here is deliberate: it allows one beat
    // per cycle on every channel.
    assign bus.in_ready = ~rst & (~slot_valid[target] | bus.out_ready[target]);
    assign accept       = bus.in_valid & bus.in_ready;

    // The one-hot load vector guarantees that at most one slot is written per cycle.
    assign load  = accept ? (4'b0001 << target) : 4'b0000;
    assign drain = slot_valid & bus.out_ready;

    // FSM state register and latched burst select.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel_latched <= 2'b00;
        end else begin
            state       <= state_next;
            sel_latched <= sel_next;
        end
    end

    // The select is latched only when a multi-beat burst starts. A single-beat
    // burst (in_last on the first beat) leaves the FSM in IDLE.
    always_comb begin
        state_next = state;
        sel_next   = sel_latched;
        unique case (state)
            IDLE: begin
                if (accept && !bus.in_last) begin
                    state_next = BURST;
                    sel_next   = bus.in_sel;
                end
            end
            BURST: begin
                if (accept && bus.in_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holding slots. A load takes priority over a drain on the same slot, so
    // the slot stays valid and takes the new beat. Data and last are written
    // only on a load. An empty or stalled slot therefore keeps its old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= 4'b0000;
            slot_last  <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                slot_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    slot_data[k]  <= bus.in_data;
                    slot_last[k]  <= bus.in_last;
                    slot_valid[k] <= 1'b1;
                end else if (drain[k]) begin
                    slot_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.out1_data = slot_data[0];
    assign bus.out2_data = slot_data[1];
    assign bus.out3_data = slot_data[2];
    assign bus.out4_data = slot_data[3];
    assign bus.out_valid = slot_valid;
    assign bus.out_last  = slot_last;

endmodule

// File: tb/tb_stream_demux4.sv
// ---------------------------------------------------------------------------
// tb_stream_demux4
//   Directed self-checking bench for stream_demux4 with WIDTH=4. A table of
//   per-cycle vectors covers reset, single beats, burst lock, backpressure and
//   independent drain. Hand-written sequences cover full-throughput bursts
//   and reset in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_stream_demux4;

    logic clk;
    logic rst;

    stream_demux4_if #(.WIDTH(4)) bus ();

    stream_demux4 #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // One table row describes one clock cycle. The inputs are applied first
    // and in_ready is compared before the edge. The slot outputs are compared
    // after the edge. exp_data is packed as {out4, out3, out2, out1}.
    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [1:0]  sel;
        logic        last;
        logic [3:0]  data;
        logic [3:0]  ready;
        logic        exp_rdy;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_last;
        logic [15:0] exp_data;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] s,
                                input logic l, input logic [3:0] d, input logic [3:0] rd,
                                input logic er, input logic [3:0] ev, input logic [3:0] el,
                                input logic [15:0] ed);
        vec_t t;
        t.rst = r;       t.valid = v;      t.sel = s;       t.last = l;
        t.data = d;      t.ready = rd;     t.exp_rdy = er;  t.exp_valid = ev;
        t.exp_last = el; t.exp_data = ed;
        return t;
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] s,
                                 input logic l, input logic [3:0] d, input logic [3:0] rd);
        rst           = r;
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_last   = l;
        bus.in_data   = d;
        bus.out_ready = rd;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 4'h0, 4'b1111);

        //              rst  vld sel    last data   ready    rdy  valid    last     {d4,d3,d2,d1}
        vecs[0]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 4'h0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 16'h0000);
        vecs[1]  = mk(1'b0, 1'b1, 2'b10, 1'b1, 4'hA, 4'b1111, 1'b1, 4'b0100, 4'b0100, 16'h0A00);
        vecs[2]  = mk(1'b0, 1'b1, 2'b00, 1'b1, 4'hC, 4'b1111, 1'b1, 4'b0001, 4'b0101, 16'h0A0C);
        vecs[3]  = mk(1'b0, 1'b1, 2'b01, 1'b0, 4'h1, 4'b1111, 1'b1, 4'b0010, 4'b0101, 16'h0A1C);
        vecs[4]  = mk(1'b0, 1'b1, 2'b11, 1'b0, 4'h2, 4'b1111, 1'b1, 4'b0010, 4'b0101, 16'h0A2C);
        vecs[5]  = mk(1'b0, 1'b1, 2'b11, 1'b1, 4'h3, 4'b1111, 1'b1, 4'b0010, 4'b0111, 16'h0A3C);
        vecs[6]  = mk(1'b0, 1'b1, 2'b11, 1'b1, 4'h4, 4'b1111, 1'b1, 4'b1000, 4'b1111, 16'h4A3C);
        vecs[7]  = mk(1'b0, 1'b1, 2'b00, 1'b1, 4'h5, 4'b1110, 1'b1, 4'b0001, 4'b1111, 16'h4A35);
        vecs[8]  = mk(1'b0, 1'b1, 2'b00, 1'b1, 4'h6, 4'b1110, 1'b0, 4'b0001, 4'b1111, 16'h4A35);
        vecs[9]  = mk(1'b0, 1'b1, 2'b00, 1'b1, 4'h6, 4'b1111, 1'b1, 4'b0001, 4'b1111, 16'h4A36);
        vecs[10] = mk(1'b0, 1'b1, 2'b10, 1'b1, 4'h7, 4'b1011, 1'b1, 4'b0100, 4'b1111, 16'h4736);
        vecs[11] = mk(1'b0, 1'b1, 2'b11, 1'b1, 4'h8, 4'b1011, 1'b1, 4'b1100, 4'b1111, 16'h8736);
        vecs[12] = mk(1'b0, 1'b1, 2'b11, 1'b1, 4'h9, 4'b1011, 1'b1, 4'b1100, 4'b1111, 16'h9736);
        vecs[13] = mk(1'b0, 1'b0, 2'b11, 1'b1, 4'h9, 4'b1111, 1'b1, 4'b0000, 4'b1111, 16'h9736);

        stepEdge();

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].sel, vecs[i].last,
                          vecs[i].data, vecs[i].ready);
            #2;
            checkOutput($sformatf("vec%0d in_ready", i), {15'd0, bus.in_ready},
                        {15'd0, vecs[i].exp_rdy});
            stepEdge();
            checkOutput($sformatf("vec%0d out_valid", i), {12'd0, bus.out_valid},
                        {12'd0, vecs[i].exp_valid});
            checkOutput($sformatf("vec%0d out_last", i), {12'd0, bus.out_last},
                        {12'd0, vecs[i].exp_last});
            checkOutput($sformatf("vec%0d out_data", i),
                        {bus.out4_data, bus.out3_data, bus.out2_data, bus.out1_data},
                        vecs[i].exp_data);
        end

        // Full throughput: eight back-to-back beats to ch2, one beat per cycle.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 2'b01, (i == 7), 4'(i), 4'b1111);
            #2;
            checkOutput($sformatf("thru%0d in_ready", i), {15'd0, bus.in_ready}, 16'd1);
            stepEdge();
            checkOutput($sformatf("thru%0d out_valid", i), {12'd0, bus.out_valid}, 16'h0002);
            checkOutput($sformatf("thru%0d out2_data", i), {12'd0, bus.out2_data}, 16'(i));
            checkOutput($sformatf("thru%0d out_last", i), {15'd0, bus.out_last[1]},
                        (i == 7) ? 16'd1 : 16'd0);
        end
        applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 4'h0, 4'b1111);
        stepEdge();
        checkOutput("thru drained out_valid", {12'd0, bus.out_valid}, 16'h0000);

        // Reset in the middle of a burst. Two beats of a four-beat burst go to
        // ch1, then reset arrives while a third beat is offered.
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 4'h1, 4'b1111);
        stepEdge();
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 4'h2, 4'b1111);
        stepEdge();
        checkOutput("midburst out1_data", {12'd0, bus.out1_data}, 16'h0002);
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 4'h3, 4'b1111);
        #2;
        checkOutput("rst in_ready", {15'd0, bus.in_ready}, 16'd0);
        stepEdge();
        checkOutput("rst out_valid", {12'd0, bus.out_valid}, 16'h0000);
        checkOutput("rst out_last", {12'd0, bus.out_last}, 16'h0000);
        checkOutput("rst out_data",
                    {bus.out4_data, bus.out3_data, bus.out2_data, bus.out1_data}, 16'h0000);
        // After reset the FSM must be IDLE again, so in_sel is honoured.
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b1, 4'hB, 4'b1111);
        #2;
        checkOutput("post-rst in_ready", {15'd0, bus.in_ready}, 16'd1);
        stepEdge();
        checkOutput("post-rst out_valid", {12'd0, bus.out_valid}, 16'h0004);
        checkOutput("post-rst out3_data", {12'd0, bus.out3_data}, 16'h000B);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'b1111);
        stepEdge();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
